// File: rtl/ex_mem_stage_if.sv
// rtl/ex_mem_stage_if.sv - ID/EX operand/control bundle in, EX/MEM register outputs out
// exmem_ovf exists only when EX_OVF_DETECT_EN is defined.
interface ex_mem_stage_if;
    logic        id_valid;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rd;
    logic        alu_src;
    logic [2:0]  alu_op;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_mem_to_reg;
    logic [1:0]  forwardA;
    logic [1:0]  forwardB;
    logic [31:0] wb_data;

    logic        exmem_valid;
    logic        exmem_reg_write;
    logic        exmem_mem_read;
    logic        exmem_mem_write;
    logic        exmem_mem_to_reg;
    logic        exmem_zero;
    logic [31:0] exmem_alu_result;
    logic [31:0] exmem_write_data;
    logic [4:0]  exmem_rd;
`ifdef EX_OVF_DETECT_EN
    logic        exmem_ovf;
`endif

    modport master (
`ifdef EX_OVF_DETECT_EN
        input  exmem_ovf,
`endif
        output id_valid, id_rs_data, id_rt_data, id_imm, id_rd, alu_src, alu_op,
        output id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
        output forwardA, forwardB, wb_data,
        input  exmem_valid, exmem_reg_write, exmem_mem_read, exmem_mem_write,
        input  exmem_mem_to_reg, exmem_zero, exmem_alu_result, exmem_write_data, exmem_rd
    );

    modport slave (
`ifdef EX_OVF_DETECT_EN
        output exmem_ovf,
`endif
        input  id_valid, id_rs_data, id_rt_data, id_imm, id_rd, alu_src, alu_op,
        input  id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
        input  forwardA, forwardB, wb_data,
        output exmem_valid, exmem_reg_write, exmem_mem_read, exmem_mem_write,
        output exmem_mem_to_reg, exmem_zero, exmem_alu_result, exmem_write_data, exmem_rd
    );
endinterface

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX stage ALU with forwarding muxes feeding the EX/MEM pipeline register
// Optional EX_OVF_DETECT_EN adds registered exmem_ovf and suppresses reg_write on ADD/SUB overflow.
module ex_mem_stage (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    ex_mem_stage_if.slave   bus
);
    logic        valid_q, valid_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic        zero_q, zero_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] write_data_q, write_data_d;
    logic [4:0]  rd_q, rd_d;
`ifdef EX_OVF_DETECT_EN
    logic        ovf_q, ovf_d;
    logic        alu_ovf;
`endif

    logic [31:0] op_a, fwd_b, op_b, sum, diff, alu_out;
    logic        load_bubble;

    // Forward path 10 reads the register output, so a held result keeps forwarding during stall.
    always_comb begin
        op_a = bus.id_rs_data;
        case (bus.forwardA)
            2'b01:   op_a = bus.wb_data;
            2'b10:   op_a = alu_result_q;
            default: op_a = bus.id_rs_data;
        endcase
        fwd_b = bus.id_rt_data;
        case (bus.forwardB)
            2'b01:   fwd_b = bus.wb_data;
            2'b10:   fwd_b = alu_result_q;
            default: fwd_b = bus.id_rt_data;
        endcase
        op_b = bus.alu_src ? bus.id_imm : fwd_b;
        sum  = op_a + op_b;
        diff = op_a - op_b;
        alu_out = 32'd0;
        case (bus.alu_op)
            3'b000:  alu_out = op_a & op_b;
            3'b001:  alu_out = op_a | op_b;
            3'b010:  alu_out = sum;
            3'b110:  alu_out = diff;
            3'b111:  alu_out = {31'd0, ($signed(op_a) < $signed(op_b))};
            default: alu_out = 32'd0;
        endcase
`ifdef EX_OVF_DETECT_EN
        alu_ovf = 1'b0;
        if (bus.alu_op == 3'b010)
            alu_ovf = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
        else if (bus.alu_op == 3'b110)
            alu_ovf = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
`endif
    end

    // flush > stall > load; a load without id_valid degrades to a bubble.
    assign load_bubble = flush || (!stall && !bus.id_valid);

    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        zero_d       = zero_q;
        alu_result_d = alu_result_q;
        write_data_d = write_data_q;
        rd_d         = rd_q;
`ifdef EX_OVF_DETECT_EN
        ovf_d        = ovf_q;
`endif
        if (load_bubble) begin
            valid_d      = 1'b0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            zero_d       = 1'b0;
`ifdef EX_OVF_DETECT_EN
            ovf_d        = 1'b0;
`endif
        end else if (!stall) begin
            valid_d      = 1'b1;
            mem_read_d   = bus.id_mem_read;
            mem_write_d  = bus.id_mem_write;
            mem_to_reg_d = bus.id_mem_to_reg;
            zero_d       = (alu_out == 32'd0);
            alu_result_d = alu_out;
            write_data_d = fwd_b;
            rd_d         = bus.id_rd;
`ifdef EX_OVF_DETECT_EN
            ovf_d        = alu_ovf;
            reg_write_d  = bus.id_reg_write && !alu_ovf;
`else
            reg_write_d  = bus.id_reg_write;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            zero_q       <= 1'b0;
            alu_result_q <= 32'd0;
            write_data_q <= 32'd0;
            rd_q         <= 5'd0;
`ifdef EX_OVF_DETECT_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            zero_q       <= zero_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            rd_q         <= rd_d;
`ifdef EX_OVF_DETECT_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign bus.exmem_valid      = valid_q;
    assign bus.exmem_reg_write  = reg_write_q;
    assign bus.exmem_mem_read   = mem_read_q;
    assign bus.exmem_mem_write  = mem_write_q;
    assign bus.exmem_mem_to_reg = mem_to_reg_q;
    assign bus.exmem_zero       = zero_q;
    assign bus.exmem_alu_result = alu_result_q;
    assign bus.exmem_write_data = write_data_q;
    assign bus.exmem_rd         = rd_q;
`ifdef EX_OVF_DETECT_EN
    assign bus.exmem_ovf        = ovf_q;
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - directed table, corner sequences and random model check of ex_mem_stage
module tb_ex_mem_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic stall = 1'b0;
    logic flush = 1'b0;
    int   total = 0;
    int   bad = 0;

`ifdef EX_OVF_DETECT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    ex_mem_stage_if bus ();
    ex_mem_stage dut (.clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fa, fb;
        logic        src;
        logic [2:0]  op;
        logic [31:0] rs, rt, imm, wb;
        logic [4:0]  rd;
        logic        rw, mr, mw, mtr;
        logic [31:0] e_res;
        logic        e_zero;
        logic [31:0] e_wd;
        logic        e_ovf;
    } vec_t;

    vec_t tbl [12];

    // reference model state
    logic        m_valid, m_rw, m_mr, m_mw, m_mtr, m_zero, m_ovf;
    logic [31:0] m_res, m_wd;
    logic [4:0]  m_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_ovf(input logic exp);
`ifdef EX_OVF_DETECT_EN
        chk("ovf", {31'd0, bus.exmem_ovf}, {31'd0, exp});
`else
        if (exp === 1'bx) $display("unreachable");
`endif
    endtask

    task automatic chk_ctrl_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, bus.exmem_valid}, 32'd0);
        chk({tag, "_rw"},    {31'd0, bus.exmem_reg_write}, 32'd0);
        chk({tag, "_mr"},    {31'd0, bus.exmem_mem_read}, 32'd0);
        chk({tag, "_mw"},    {31'd0, bus.exmem_mem_write}, 32'd0);
        chk({tag, "_mtr"},   {31'd0, bus.exmem_mem_to_reg}, 32'd0);
    endtask

    task automatic drive(input vec_t v, input logic valid);
        bus.id_valid = valid;  bus.forwardA = v.fa;  bus.forwardB = v.fb;
        bus.alu_src = v.src;   bus.alu_op = v.op;
        bus.id_rs_data = v.rs; bus.id_rt_data = v.rt; bus.id_imm = v.imm; bus.wb_data = v.wb;
        bus.id_rd = v.rd;      bus.id_reg_write = v.rw; bus.id_mem_read = v.mr;
        bus.id_mem_write = v.mw; bus.id_mem_to_reg = v.mtr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'b000: return a & b;
            3'b001: return a | b;
            3'b010: return 32'(sa + sb);
            3'b110: return 32'(sa - sb);
            3'b111: return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint s;
        if (op == 3'b010)      s = longint'($signed(a)) + longint'($signed(b));
        else if (op == 3'b110) s = longint'($signed(a)) - longint'($signed(b));
        else return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    vec_t v;
    vec_t r;
    logic [31:0] a, fb, b, res;
    logic        ov;

    initial begin
        tbl[0]  = '{2'b00,2'b00,1'b0,3'b010,32'd5,32'd7,32'd0,32'd0,5'd3,1'b1,1'b0,1'b0,1'b0,32'd12,1'b0,32'd7,1'b0};
        tbl[1]  = '{2'b10,2'b00,1'b0,3'b110,32'd999,32'd12,32'd0,32'd0,5'd4,1'b1,1'b0,1'b0,1'b0,32'd0,1'b1,32'd12,1'b0};
        tbl[2]  = '{2'b00,2'b01,1'b0,3'b010,32'd1,32'd100,32'd0,32'd9,5'd5,1'b1,1'b0,1'b0,1'b0,32'd10,1'b0,32'd9,1'b0};
        tbl[3]  = '{2'b00,2'b00,1'b0,3'b111,32'hFFFF_FFFF,32'd1,32'd0,32'd0,5'd6,1'b1,1'b1,1'b0,1'b1,32'd1,1'b0,32'd1,1'b0};
        tbl[4]  = '{2'b00,2'b00,1'b0,3'b111,32'd1,32'hFFFF_FFFF,32'd0,32'd0,5'd7,1'b1,1'b0,1'b0,1'b0,32'd0,1'b1,32'hFFFF_FFFF,1'b0};
        tbl[5]  = '{2'b00,2'b00,1'b0,3'b011,32'd5,32'd3,32'd0,32'd0,5'd8,1'b1,1'b0,1'b0,1'b0,32'd0,1'b1,32'd3,1'b0};
        tbl[6]  = '{2'b00,2'b00,1'b1,3'b000,32'h0000_F0F0,32'h0000_1234,32'h0000_0FF0,32'd0,5'd9,1'b0,1'b0,1'b1,1'b0,32'h0000_00F0,1'b0,32'h0000_1234,1'b0};
        tbl[7]  = '{2'b00,2'b00,1'b0,3'b001,32'h100,32'h011,32'd0,32'd0,5'd10,1'b1,1'b0,1'b0,1'b0,32'h111,1'b0,32'h011,1'b0};
        tbl[8]  = '{2'b11,2'b11,1'b0,3'b010,32'd2,32'd3,32'd0,32'd0,5'd11,1'b1,1'b0,1'b0,1'b0,32'd5,1'b0,32'd3,1'b0};
        tbl[9]  = '{2'b00,2'b00,1'b0,3'b110,32'd0,32'd1,32'd0,32'd0,5'd31,1'b1,1'b0,1'b0,1'b0,32'hFFFF_FFFF,1'b0,32'd1,1'b0};
        tbl[10] = '{2'b00,2'b00,1'b0,3'b010,32'h7FFF_FFFF,32'd1,32'd0,32'd0,5'd12,1'b1,1'b0,1'b0,1'b0,32'h8000_0000,1'b0,32'd1,1'b1};
        tbl[11] = '{2'b10,2'b00,1'b0,3'b010,32'd0,32'hFFFF_FFFF,32'd0,32'd0,5'd13,1'b1,1'b0,1'b0,1'b0,32'h7FFF_FFFF,1'b0,32'hFFFF_FFFF,1'b1};

        drive(tbl[0], 1'b0);
        #12;
        chk_ctrl_zero("reset");
        chk("reset_res", bus.exmem_alu_result, 32'd0);
        chk("reset_rd", {27'd0, bus.exmem_rd}, 32'd0);
        rst = 1'b1;

        // directed table, back-to-back so forwardA=10 rows chain off the prior row
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i], 1'b1);
            tick();
            chk($sformatf("t%0d_valid", i), {31'd0, bus.exmem_valid}, 32'd1);
            chk($sformatf("t%0d_res", i), bus.exmem_alu_result, tbl[i].e_res);
            chk($sformatf("t%0d_zero", i), {31'd0, bus.exmem_zero}, {31'd0, tbl[i].e_zero});
            chk($sformatf("t%0d_wd", i), bus.exmem_write_data, tbl[i].e_wd);
            chk($sformatf("t%0d_rd", i), {27'd0, bus.exmem_rd}, {27'd0, tbl[i].rd});
            chk($sformatf("t%0d_rw", i), {31'd0, bus.exmem_reg_write},
                {31'd0, tbl[i].rw & ~(OVF_EN & tbl[i].e_ovf)});
            chk($sformatf("t%0d_mr", i), {31'd0, bus.exmem_mem_read}, {31'd0, tbl[i].mr});
            chk($sformatf("t%0d_mw", i), {31'd0, bus.exmem_mem_write}, {31'd0, tbl[i].mw});
            chk($sformatf("t%0d_mtr", i), {31'd0, bus.exmem_mem_to_reg}, {31'd0, tbl[i].mtr});
            chk_ovf(tbl[i].e_ovf);
        end

        // load then hold across three stall cycles with churning inputs
        drive(tbl[0], 1'b1);
        tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            v = tbl[(k * 5 + 1) % 12];
            v.fa = 2'b10;
            drive(v, k[0]);
            tick();
            chk($sformatf("stall%0d_res", k), bus.exmem_alu_result, 32'd12);
            chk($sformatf("stall%0d_rd", k), {27'd0, bus.exmem_rd}, 32'd3);
            chk($sformatf("stall%0d_valid", k), {31'd0, bus.exmem_valid}, 32'd1);
            chk($sformatf("stall%0d_rw", k), {31'd0, bus.exmem_reg_write}, 32'd1);
            chk($sformatf("stall%0d_wd", k), bus.exmem_write_data, 32'd7);
        end
        flush = 1'b1;
        drive(tbl[3], 1'b1);
        tick();
        chk_ctrl_zero("stall_flush");
        stall = 1'b0;
        flush = 1'b0;

        // bubble load with every control bit requested
        v = tbl[3];
        v.mw = 1'b1;
        drive(v, 1'b1);
        tick();
        chk("pre_bubble_mr", {31'd0, bus.exmem_mem_read}, 32'd1);
        drive(v, 1'b0);
        tick();
        chk_ctrl_zero("bubble");

        // asynchronous reset between edges, overriding stall and flush
        drive(tbl[3], 1'b1);
        tick();
        #2;
        rst = 1'b0;
        stall = 1'b1;
        flush = 1'b1;
        #1;
        chk_ctrl_zero("async_rst");
        chk("async_rst_res", bus.exmem_alu_result, 32'd0);
        chk("async_rst_rd", {27'd0, bus.exmem_rd}, 32'd0);
        tick();
        chk_ctrl_zero("rst_held");
        flush = 1'b0;
        #2;
        rst = 1'b1;
        tick();
        chk_ctrl_zero("post_rst_stall");
        stall = 1'b0;
        drive(tbl[0], 1'b1);
        tick();
        chk("post_rst_load_res", bus.exmem_alu_result, 32'd12);
        chk("post_rst_load_valid", {31'd0, bus.exmem_valid}, 32'd1);

        // random phase against the reference model, starting from a fresh reset
        #2;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_mtr = 0; m_zero = 0; m_ovf = 0;
        m_res = 0; m_wd = 0; m_rd = 0;
        for (int n = 0; n < 400; n++) begin
            r.fa = 2'($urandom_range(0, 3));
            r.fb = 2'($urandom_range(0, 3));
            if (!m_valid && r.fa == 2'b10) r.fa = 2'b00;
            if (!m_valid && r.fb == 2'b10) r.fb = 2'b00;
            r.src = 1'($urandom_range(0, 1));
            r.op = 3'($urandom_range(0, 7));
            r.rs = pick32(); r.rt = pick32(); r.imm = pick32(); r.wb = pick32();
            r.rd = 5'($urandom); r.rw = 1'($urandom); r.mr = 1'($urandom);
            r.mw = 1'($urandom); r.mtr = 1'($urandom);
            drive(r, $urandom_range(0, 9) < 8);
            stall = $urandom_range(0, 9) < 2;
            flush = $urandom_range(0, 9) < 1;

            a  = (r.fa == 2'b01) ? r.wb : (r.fa == 2'b10) ? m_res : r.rs;
            fb = (r.fb == 2'b01) ? r.wb : (r.fb == 2'b10) ? m_res : r.rt;
            b  = r.src ? r.imm : fb;
            res = ref_alu(r.op, a, b);
            ov  = ref_ovf(r.op, a, b);

            if (flush || (!stall && !bus.id_valid)) begin
                m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_mtr = 0; m_ovf = 0;
            end else if (!stall) begin
                m_valid = 1; m_mr = r.mr; m_mw = r.mw; m_mtr = r.mtr;
                m_rw = r.rw & ~(OVF_EN & ov);
                m_ovf = ov; m_res = res; m_zero = (res == 0); m_wd = fb; m_rd = r.rd;
            end
            tick();
            chk("rnd_valid", {31'd0, bus.exmem_valid}, {31'd0, m_valid});
            chk("rnd_rw", {31'd0, bus.exmem_reg_write}, {31'd0, m_rw});
            chk("rnd_mr", {31'd0, bus.exmem_mem_read}, {31'd0, m_mr});
            chk("rnd_mw", {31'd0, bus.exmem_mem_write}, {31'd0, m_mw});
            chk("rnd_mtr", {31'd0, bus.exmem_mem_to_reg}, {31'd0, m_mtr});
            chk_ovf(m_ovf);
            if (m_valid) begin
                chk("rnd_res", bus.exmem_alu_result, m_res);
                chk("rnd_zero", {31'd0, bus.exmem_zero}, {31'd0, m_zero});
                chk("rnd_wd", bus.exmem_write_data, m_wd);
                chk("rnd_rd", {27'd0, bus.exmem_rd}, {27'd0, m_rd});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: stall  input  1  hold the EX/MEM register contents.
REQ-004 SHALL provide: flush  input  1  load a bubble into EX/MEM.
REQ-005 SHALL provide: id_valid  input  1  ID/EX slot holds a real instruction.
REQ-006 SHALL provide: id_rs_data, id_rt_data, id_imm  input  32 each  ID/EX operands and sign-extended immediate.
REQ-007 SHALL provide: id_rd  input  5  destination register; alu_src  input  1  1 selects id_imm for operand B.
REQ-008 SHALL provide: alu_op  input  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed).
REQ-009 SHALL provide: id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  input  1 each  ID/EX control bits.
REQ-010 SHALL provide: forwardA, forwardB  input  2 each  operand select from the forwarding unit.
REQ-011 SHALL provide: wb_data  input  32  MEM/WB writeback value.
REQ-012 SHALL provide: exmem_valid, exmem_reg_write, exmem_mem_read, exmem_mem_write, exmem_mem_to_reg, exmem_zero  output  1 each, registered.
REQ-013 SHALL provide: exmem_alu_result, exmem_write_data  output  32 each; exmem_rd  output  5; all registered.

Function
REQ-014 Operand A SHALL be id_rs_data for forwardA 00, wb_data for 01, current exmem_alu_result for 10, and id_rs_data for 11.
REQ-015 Forwarded B SHALL be selected from id_rt_data by forwardB with the same encoding.
REQ-016 ALU operand B SHALL be id_imm when alu_src=1, else forwarded B.
REQ-017 ADD/SUB SHALL wrap modulo 2^32.
REQ-018 SLT SHALL yield 32'd1 when A<B as two's-complement values, else 32'd0.
REQ-019 Undefined alu_op codes SHALL yield 32'd0.
REQ-020 The zero flag SHALL be 1 exactly when the 32-bit ALU result is 0.
REQ-021 exmem_write_data SHALL capture forwarded B, never id_imm.
REQ-022 Latency SHALL be one cycle: values present before edge N appear on outputs after edge N.
REQ-023 Priority per edge SHALL be flush > stall > load.
REQ-024 Flush SHALL set exmem_valid=0 and clear exmem_reg_write, exmem_mem_read, exmem_mem_write and exmem_mem_to_reg; data fields are don't-care.
REQ-025 Stall without flush SHALL hold every output unchanged, including across multiple consecutive stall cycles.
REQ-026 Load with id_valid=0 SHALL behave as flush, so a bubble never asserts any control output.
REQ-027 Load with id_valid=1 SHALL capture all fields and set exmem_valid=1.
REQ-028 Control outputs SHALL always be 0 whenever exmem_valid=0.
REQ-029 Forwarding select 10 SHALL use the pre-edge exmem_alu_result, so back-to-back dependent instructions chain correctly.
REQ-030 During stall, the forwarded value SHALL remain the held result.

Reset
REQ-031 rst=0 SHALL immediately, without waiting for clk, force every output to 0, including exmem_rd=5'd0 and exmem_valid=0.
REQ-032 rst=0 asserted mid-stall or mid-flush SHALL override both; the first edge after release SHALL follow REQ-023.

Configuration
REQ-033 Macro EX_OVF_DETECT_EN SHALL, when defined, add output exmem_ovf (1 bit, registered, reset 0).
REQ-034 With EX_OVF_DETECT_EN, exmem_ovf SHALL be set to signed overflow of ADD/SUB on load, 0 for other ops and bubbles, and held on stall.
REQ-035 With EX_OVF_DETECT_EN, an overflowing instruction with id_reg_write=1 SHALL load exmem_reg_write=0.
REQ-036 Without EX_OVF_DETECT_EN, the exmem_ovf port SHALL not exist and overflow SHALL be silently wrapped.

Verification
REQ-037 ADD with rs=5, rt=7, forward 00/00, rd=3, valid -> next cycle exmem_alu_result=12, exmem_rd=3, reg_write=1, zero=0.
REQ-038 Dependent pair: cycle 1 ADD result 12, cycle 2 SUB with forwardA=10, rt=12 -> result 0, zero=1; forwardB=01 with wb_data=9 uses 9 for B.
REQ-039 Load an instruction, then stall 3 cycles with changing inputs -> outputs constant; stall+flush together -> valid=0 and all controls 0.
REQ-040 SLT with A=0xFFFFFFFF, B=1 -> result 1; A=1, B=0xFFFFFFFF -> result 0; alu_op=011 -> result 0.
REQ-041 Assert rst low between clock edges while valid=1 -> all outputs 0 immediately; after release, valid=0 until the next load.
REQ-042 With EX_OVF_DETECT_EN, ADD 0x7FFFFFFF+1 -> result 0x80000000, exmem_ovf=1, reg_write=0; without the macro, reg_write=1.
